// File: rtl/wr_ptr_ctrl_top_1_pkg.sv
// Shared definitions for the async FIFO write-pointer controller and its level calculator.
package wr_ptr_ctrl_top_1_pkg;

    localparam int A_LENGTH = 4;

    typedef enum logic [1:0] {
        WS_INIT = 2'd0,
        WS_RUN  = 2'd1,
        WS_FULL = 2'd2
    } ws_state_e;

    function automatic int depth_of(input int ptr_w);
        return 1 << (ptr_w - 1);
    endfunction

endpackage

// File: rtl/wr_ptr_ctrl_top_1_if.sv
// Write-side user/RAM/synchronizer signal bundle; wr_level exists only with FIFO_WR_LEVEL_EN.
interface wr_ptr_ctrl_top_1_if #(
    parameter int PTR_W = wr_ptr_ctrl_top_1_pkg::A_LENGTH
);
    logic             wr_en;
    logic             clr_ovf;
    logic [PTR_W-1:0] b_rd_ptr_sync;
    logic [PTR_W-1:0] b_wr_ptr;
    logic [PTR_W-2:0] waddr;
    logic             wr_inc;
    logic             full;
    logic             wr_ack;
    logic             overflow;
`ifdef FIFO_WR_LEVEL_EN
    logic [PTR_W-1:0] wr_level;
`endif

    modport master (
        output wr_en, clr_ovf, b_rd_ptr_sync,
`ifdef FIFO_WR_LEVEL_EN
        input  wr_level,
`endif
        input  b_wr_ptr, waddr, wr_inc, full, wr_ack, overflow
    );

    modport slave (
        input  wr_en, clr_ovf, b_rd_ptr_sync,
`ifdef FIFO_WR_LEVEL_EN
        output wr_level,
`endif
        output b_wr_ptr, waddr, wr_inc, full, wr_ack, overflow
    );

endinterface

// File: rtl/wr_level_calc_top_1.sv
// Modular pointer difference and full compare; reused by the read-side empty controller.
module wr_level_calc_top_1
    import wr_ptr_ctrl_top_1_pkg::*;
#(
    parameter int PTR_W = A_LENGTH
) (
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] level,
    output logic             at_full
);
    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(depth_of(PTR_W));

    // Unsigned subtraction wraps naturally across the pointer rollover.
    assign level   = wr_ptr - rd_ptr;
    assign at_full = (level >= DEPTH_V);

endmodule

// File: rtl/wr_ptr_ctrl_top_1.sv
// Async FIFO write-side controller: write pointer, full/ack/overflow flags, INIT settle window.
// Optional registered fill level output when FIFO_WR_LEVEL_EN is defined.
module wr_ptr_ctrl_top_1
    import wr_ptr_ctrl_top_1_pkg::*;
#(
    parameter int PTR_W    = A_LENGTH,
    parameter int INIT_CYC = 3
) (
    input  logic                 wr_clk,
    input  logic                 reset,
    wr_ptr_ctrl_top_1_if.slave   bus
);
    localparam logic [PTR_W-1:0] DEPTH_V   = PTR_W'(depth_of(PTR_W));
    localparam int               CNT_W     = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);

    ws_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             full_q, full_d;
    logic             ack_q, ack_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic [PTR_W-1:0] level_next;
    logic             at_full;
    logic             over_depth;
`ifdef FIFO_WR_LEVEL_EN
    logic [PTR_W-1:0] level_q, level_d;
`endif

    assign accept     = bus.wr_en && (state_q == WS_RUN);
    assign ptr_d      = ptr_q + PTR_W'(accept);
    assign over_depth = (level_next > DEPTH_V);

    // Level as it will stand after this edge, so a same-cycle read advance nets out.
    wr_level_calc_top_1 #(.PTR_W(PTR_W)) u_level (
        .wr_ptr  (ptr_d),
        .rd_ptr  (bus.b_rd_ptr_sync),
        .level   (level_next),
        .at_full (at_full)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q <= WS_INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            full_q  <= 1'b1;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef FIFO_WR_LEVEL_EN
            level_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
`ifdef FIFO_WR_LEVEL_EN
            level_q <= level_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WS_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = at_full ? WS_FULL : WS_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WS_RUN, WS_FULL: state_d = at_full ? WS_FULL : WS_RUN;
            default:         state_d = WS_INIT;
        endcase
    end

    always_comb begin
        full_d = (state_d != WS_RUN);
        ack_d  = accept;
        ovf_d  = ovf_q;
        if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
        // A refused write or a corrupt (over-depth) level both latch overflow; set beats clear.
        if (((state_q == WS_FULL) && bus.wr_en) ||
            ((state_q != WS_INIT) && over_depth)) begin
            ovf_d = 1'b1;
        end
`ifdef FIFO_WR_LEVEL_EN
        level_d = (state_d == WS_INIT) ? '0 : level_next;
`endif
    end

    assign bus.b_wr_ptr = ptr_q;
    assign bus.waddr    = ptr_q[PTR_W-2:0];
    assign bus.wr_inc   = accept;
    assign bus.full     = full_q;
    assign bus.wr_ack   = ack_q;
    assign bus.overflow = ovf_q;
`ifdef FIFO_WR_LEVEL_EN
    assign bus.wr_level = level_q;
`endif

endmodule

// File: tb/tb_wr_ptr_ctrl_top_1.sv
// Table-driven scoreboard bench for wr_ptr_ctrl_top_1 (PTR_W=4, DEPTH=8, INIT_CYC=3).
module tb_wr_ptr_ctrl_top_1;
    localparam int PTR_W = 4;

    logic wr_clk = 1'b0;
    logic reset  = 1'b1;
    always #5 wr_clk = ~wr_clk;

    wr_ptr_ctrl_top_1_if #(.PTR_W(PTR_W)) bus ();

    wr_ptr_ctrl_top_1 #(.PTR_W(PTR_W), .INIT_CYC(3)) dut (
        .wr_clk (wr_clk),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        logic       wr_en;
        logic       clr;
        logic [3:0] sync;
        logic       inc;
        logic [2:0] waddr;
        logic [3:0] ptr;
        logic       full;
        logic       ack;
        logic       ovf;
        logic [3:0] lvl;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] ptr;
        logic       full;
        logic       ack;
        logic       ovf;
        logic [3:0] lvl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic c, input int s, input logic inc, input int wa,
                       input int p, input logic f, input logic a, input logic o, input int l);
        vec_t v;
        v.wr_en = w;  v.clr = c;  v.sync = 4'(s);
        v.inc = inc;  v.waddr = 3'(wa);
        v.ptr = 4'(p); v.full = f; v.ack = a; v.ovf = o; v.lvl = 4'(l);
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        bus.wr_en         = v.wr_en;
        bus.clr_ovf       = v.clr;
        bus.b_rd_ptr_sync = v.sync;
        #1;
        check("wr_inc", idx, 32'(bus.wr_inc), 32'(v.inc));
        check("waddr",  idx, 32'(bus.waddr),  32'(v.waddr));
        e.idx = idx; e.ptr = v.ptr; e.full = v.full; e.ack = v.ack; e.ovf = v.ovf; e.lvl = v.lvl;
        sb.push_back(e);
        @(posedge wr_clk);
        #1;
        e = sb.pop_front();
        check("b_wr_ptr", e.idx, 32'(bus.b_wr_ptr), 32'(e.ptr));
        check("full",     e.idx, 32'(bus.full),     32'(e.full));
        check("wr_ack",   e.idx, 32'(bus.wr_ack),   32'(e.ack));
        check("overflow", e.idx, 32'(bus.overflow), 32'(e.ovf));
`ifdef FIFO_WR_LEVEL_EN
        check("wr_level", e.idx, 32'(bus.wr_level), 32'(e.lvl));
`endif
    endtask

    task automatic check_reset_values(input int tag);
        check("rst_b_wr_ptr", tag, 32'(bus.b_wr_ptr), 32'd0);
        check("rst_waddr",    tag, 32'(bus.waddr),    32'd0);
        check("rst_wr_inc",   tag, 32'(bus.wr_inc),   32'd0);
        check("rst_full",     tag, 32'(bus.full),     32'd1);
        check("rst_wr_ack",   tag, 32'(bus.wr_ack),   32'd0);
        check("rst_overflow", tag, 32'(bus.overflow), 32'd0);
`ifdef FIFO_WR_LEVEL_EN
        check("rst_wr_level", tag, 32'(bus.wr_level), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus.wr_en         = 1'b0;
        bus.clr_ovf       = 1'b0;
        bus.b_rd_ptr_sync = '0;

        //  wr_en clr sync | inc waddr | ptr full ack ovf lvl
        add(1, 0, 0,  0, 0,  0, 1, 0, 0, 0);   // INIT 1
        add(1, 0, 0,  0, 0,  0, 1, 0, 0, 0);   // INIT 2
        add(1, 0, 0,  0, 0,  0, 0, 0, 0, 0);   // INIT 3 -> RUN
        for (int k = 0; k < 8; k++)
            add(1, 0, 0,  1, k,  k + 1, (k == 7), 1, 0, k + 1);
        add(0, 0, 1,  0, 0,  8, 0, 0, 0, 7);   // sync advances, full drops
        add(1, 0, 1,  1, 0,  9, 1, 1, 0, 8);   // one write refills
        add(1, 0, 1,  0, 1,  9, 1, 0, 1, 8);   // refused -> overflow
        add(1, 0, 1,  0, 1,  9, 1, 0, 1, 8);
        add(0, 1, 1,  0, 1,  9, 1, 0, 0, 8);   // clear
        add(1, 0, 1,  0, 1,  9, 1, 0, 1, 8);
        add(1, 1, 1,  0, 1,  9, 1, 0, 1, 8);   // set beats clear
        add(0, 1, 1,  0, 1,  9, 1, 0, 0, 8);
        add(0, 0, 2,  0, 1,  9, 0, 0, 0, 7);
        add(1, 0, 3,  1, 1, 10, 0, 1, 0, 7);   // write + read same cycle
        add(1, 0, 4,  1, 2, 11, 0, 1, 0, 7);
        add(1, 0, 5,  1, 3, 12, 0, 1, 0, 7);
        add(1, 0, 6,  1, 4, 13, 0, 1, 0, 7);
        add(1, 0, 7,  1, 5, 14, 0, 1, 0, 7);
        add(1, 0, 8,  1, 6, 15, 0, 1, 0, 7);
        add(1, 0, 9,  1, 7,  0, 0, 1, 0, 7);   // pointer wrap 15 -> 0
        add(1, 0, 9,  1, 0,  1, 1, 1, 0, 8);
        add(0, 0, 8,  0, 1,  1, 1, 0, 1, 9);   // corrupt level 9
        add(0, 1, 9,  0, 1,  1, 1, 0, 0, 8);
        add(0, 0, 10, 0, 1,  1, 0, 0, 0, 7);
        add(1, 0, 11, 1, 1,  2, 0, 1, 0, 7);
        add(1, 0, 12, 1, 2,  3, 0, 1, 0, 7);   // sync 12 / ptr 3 stays not full
        add(1, 0, 13, 1, 3,  4, 0, 1, 0, 7);
        add(1, 0, 14, 1, 4,  5, 0, 1, 0, 7);

        repeat (2) @(posedge wr_clk);
        #1;
        check_reset_values(-1);
        @(negedge wr_clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply(i);

        // Asynchronous reset mid-burst with ptr=5 and wr_ack high.
        bus.wr_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values(-2);
        @(posedge wr_clk);
        #1;
        check_reset_values(-3);
        @(negedge wr_clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            apply(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
